neuron_acc: RTL

NEURON_ACC -- requirements
Module: neuron_acc

---
 rtl/neuron_acc.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/neuron_acc.sv
// Neuron dot-product accumulator.
// Consumes (sample, weight) pairs, accumulates N_INPUTS products per vector,
// adds a bias and emits a saturated result two cycles after the last pair.
// Stage 1 registers the full-precision product. Stage 2 accumulates the
// products and, on the last one, loads the saturated output.
module neuron_acc #(
   parameter int unsigned DIN_WIDTH    = 16,
   parameter int unsigned WEIGHT_WIDTH = 16,
   parameter int unsigned N_INPUTS     = 256,
   parameter int unsigned ACC_WIDTH    = 48,
   parameter int unsigned DOUT_WIDTH   = 32
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic signed [DIN_WIDTH-1:0]                din,
   input  logic                                       din_valid,
   input  logic signed [WEIGHT_WIDTH-1:0]             weight,
   input  logic                                       weight_valid,
   input  logic signed [DIN_WIDTH+WEIGHT_WIDTH-1:0]   bias,
   output logic signed [DOUT_WIDTH-1:0]               dout,
   output logic                                       dout_valid,
   output logic                                       dout_sat,
   output logic                                       pair_err
);

   localparam int unsigned PROD_W = DIN_WIDTH + WEIGHT_WIDTH;
   localparam int unsigned IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   // One extra bit so that adding the bias to the accumulator cannot wrap.
   localparam int unsigned SUM_W  = ACC_WIDTH + 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

   // Signed DOUT_WIDTH limits, expressed at the pre-saturation width.
   localparam logic signed [SUM_W-1:0] SAT_MAX =
      {{(SUM_W - DOUT_WIDTH + 1){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_MIN =
      {{(SUM_W - DOUT_WIDTH + 1){1'b1}}, {(DOUT_WIDTH - 1){1'b0}}};

   // Pair handshake
   logic w_fire;
   logic w_mismatch;

   // Stage 1 state
   logic [IDX_W-1:0]         r_idx;
   logic signed [PROD_W-1:0] r_prod;
   logic                     r_p_valid;
   logic                     r_p_last;

   // Stage 2 state
   logic signed [ACC_WIDTH-1:0]  r_acc;
   logic                         r_first;
   logic signed [DOUT_WIDTH-1:0] r_dout;
   logic                         r_dout_valid;
   logic                         r_dout_sat;
   logic                         r_pair_err;

   // Stage 2 combinational datapath
   logic signed [ACC_WIDTH-1:0]  w_prod_ext;
   logic signed [ACC_WIDTH-1:0]  w_acc_base;
   logic signed [ACC_WIDTH-1:0]  w_acc_next;
   logic signed [SUM_W-1:0]      w_sum;
   logic signed [DOUT_WIDTH-1:0] w_sum_sat;
   logic                         w_sum_clip;

   assign w_fire     = din_valid & weight_valid;
   assign w_mismatch = din_valid ^ weight_valid;

   // Sticky flag for a beat that arrived without its partner.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pair_err <= 1'b0;
      end else if (w_mismatch) begin
         r_pair_err <= 1'b1;
      end
   end

   // Pair index within the current vector, wraps after the last pair.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx <= '0;
      end else if (w_fire) begin
         if (r_idx == LAST_IDX) begin
            r_idx <= '0;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   // Stage 1: register the full-precision product with valid/last tags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prod    <= '0;
         r_p_valid <= 1'b0;
         r_p_last  <= 1'b0;
      end else begin
         r_p_valid <= w_fire;
         r_p_last  <= w_fire && (r_idx == LAST_IDX);
         if (w_fire) begin
            r_prod <= PROD_W'(din) * PROD_W'(weight);
         end
      end
   end

   // Accumulate, add bias and saturate to the output width.
   always_comb begin
      w_prod_ext = ACC_WIDTH'(r_prod);
      w_acc_base = r_first ? '0 : r_acc;
      w_acc_next = w_acc_base + w_prod_ext;
      w_sum      = SUM_W'(w_acc_next) + SUM_W'(bias);
      w_sum_clip = 1'b0;
      w_sum_sat  = w_sum[DOUT_WIDTH-1:0];
      if (w_sum > SAT_MAX) begin
         w_sum_clip = 1'b1;
         w_sum_sat  = SAT_MAX[DOUT_WIDTH-1:0];
      end else if (w_sum < SAT_MIN) begin
         w_sum_clip = 1'b1;
         w_sum_sat  = SAT_MIN[DOUT_WIDTH-1:0];
      end
   end

   // Stage 2: running sum; the last product restarts the next vector at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc   <= '0;
         r_first <= 1'b1;
      end else if (r_p_valid) begin
         if (r_p_last) begin
            r_acc   <= '0;
            r_first <= 1'b1;
         end else begin
            r_acc   <= w_acc_next;
            r_first <= 1'b0;
         end
      end
   end

   // Output register: one-cycle strobe, result and clip flag held between strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_dout_sat   <= 1'b0;
      end else begin
         r_dout_valid <= r_p_valid && r_p_last;
         if (r_p_valid && r_p_last) begin
            r_dout     <= w_sum_sat;
            r_dout_sat <= w_sum_clip;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign dout_sat   = r_dout_sat;
   assign pair_err   = r_pair_err;

endmodule
